top: RTL and testbench

TOP -- requirements
Module: top

---
 rtl/top.sv | 85 ++++++++
 tb/tb_top.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/top.sv
// Eight self-checking circular shift-register lanes with sticky per-lane error flags.
// Each lane is compared every cycle against a prediction derived only from its INIT constant.
module top #(
    parameter logic [31:0] INIT0 = 32'hA5C30F96,
    parameter logic [31:0] INIT1 = 32'h12345678,
    parameter logic [31:0] INIT2 = 32'hDEADBEEF,
    parameter logic [31:0] INIT3 = 32'h0F0F00FF,
    parameter logic [31:0] INIT4 = 32'h80000001,
    parameter logic [31:0] INIT5 = 32'hCAFEF00D,
    parameter logic [31:0] INIT6 = 32'h55AA33CC,
    parameter logic [31:0] INIT7 = 32'h7FFFFFFE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    output logic        tx,
    input  logic [15:0] sw,
    output logic [15:0] led
);

    localparam logic [7:0][31:0] INIT_C = {INIT7, INIT6, INIT5, INIT4,
                                           INIT3, INIT2, INIT1, INIT0};

    logic [7:0][31:0] srl_r;
    logic             phase_r;
    logic [4:0]       cnt_r;
    logic [4:0]       addr_r;
    logic [7:0]       err_r;

    logic [7:0]       q_s;
    logic [7:0]       e_s;
    logic [7:0]       d_s;
    logic [4:0]       a_s   [8];
    logic [4:0]       off_s [8];
    logic             unused_s;

    // Per-lane read address, observed bit, predicted bit and shift-in bit.
    always_comb begin
        q_s = 8'd0;
        e_s = 8'd0;
        d_s = 8'd0;
        for (int i = 0; i < 8; i++) begin
            a_s[i]   = 5'd0;
            off_s[i] = 5'd0;
        end
        for (int i = 0; i < 8; i++) begin
            a_s[i]   = addr_r + 5'(4 * i);
            // After cnt rotations, bit a holds the INIT bit at a - cnt.
            off_s[i] = a_s[i] - cnt_r;
            q_s[i]   = srl_r[i][a_s[i]];
            e_s[i]   = INIT_C[i][off_s[i]];
            d_s[i]   = srl_r[i][31];
        end
        d_s[0] = srl_r[0][31] ^ sw[0];
    end

    // Lane rotation, counters and sticky error capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            srl_r   <= INIT_C;
            phase_r <= 1'b0;
            cnt_r   <= 5'd0;
            addr_r  <= 5'd0;
            err_r   <= 8'd0;
        end else begin
            phase_r <= ~phase_r;
            addr_r  <= addr_r + 5'd1;
            err_r   <= err_r | (q_s ^ e_s);
            if (phase_r) begin
                cnt_r <= cnt_r + 5'd1;
                for (int i = 0; i < 8; i++) begin
                    srl_r[i] <= {srl_r[i][30:0], d_s[i]};
                end
            end else begin
                cnt_r <= cnt_r;
                srl_r <= srl_r;
            end
        end
    end

    assign unused_s = ^sw[15:1];
    assign led      = {q_s, err_r};
    assign tx       = rx;

endmodule

// File: tb/tb_top.sv
// Randomized directed bench for top: a ring model (fixed storage, moving base) predicts
// every lane bit and the sticky error flags; led and tx are checked each cycle.
module tb_top;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx;
    logic        tx;
    logic [15:0] sw;
    logic [15:0] led;

    top dut (.clk(clk), .rst_n(rst_n), .rx(rx), .tx(tx), .sw(sw), .led(led));

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [31:0] init_m [8];
    logic [31:0] phys   [8];
    int          t_m;
    int          k_m;
    logic [7:0]  err_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) phys[i] = init_m[i];
        t_m   = 0;
        k_m   = 0;
        err_m = 8'd0;
    endtask

    // Logical bit j of a lane after k rotations lives at phys[(j - k) mod 32].
    function automatic logic [7:0] exp_q();
        logic [7:0] r;
        r = 8'd0;
        for (int i = 0; i < 8; i++) r[i] = phys[i][((t_m + 4 * i) - k_m) & 31];
        return r;
    endfunction

    task automatic model_edge(input logic f);
        for (int i = 0; i < 8; i++) begin
            int off;
            off = ((t_m + 4 * i) - k_m) & 31;
            if (phys[i][off] !== init_m[i][off]) err_m[i] = 1'b1;
        end
        if ((t_m & 1) == 1) begin
            // The bit entering lane 0 is physical slot (31 - k); a fault flips it in place.
            if (f) phys[0][(31 - k_m) & 31] = ~phys[0][(31 - k_m) & 31];
            k_m++;
        end
        t_m++;
    endtask

    task automatic cycle(input logic f);
        sw = {15'($urandom), f};
        rx = 1'($urandom);
        #1;
        chk("tx_loop", 32'(tx), 32'(rx));
        @(posedge clk);
        model_edge(f);
        @(negedge clk);
        chk("led", 32'(led), 32'({exp_q(), err_m}));
    endtask

    task automatic check_reset_view(input string tag);
        chk({tag, "_err"}, 32'(led[7:0]), 32'd0);
        for (int i = 0; i < 8; i++) chk({tag, "_q"}, 32'(led[8 + i]), 32'(init_m[i][4 * i]));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        check_reset_view("reset");
        rst_n = 1'b1;
        #1;
        check_reset_view("release");
    endtask

    initial begin
        int start;
        bit seen;
        init_m[0] = 32'hA5C30F96; init_m[1] = 32'h12345678;
        init_m[2] = 32'hDEADBEEF; init_m[3] = 32'h0F0F00FF;
        init_m[4] = 32'h80000001; init_m[5] = 32'hCAFEF00D;
        init_m[6] = 32'h55AA33CC; init_m[7] = 32'h7FFFFFFE;
        rst_n = 1'b1;
        sw    = 16'd0;
        rx    = 1'b0;
        model_reset();

        // Reset pulse, then 1000 clean cycles across many counter wraps.
        do_reset();
        chk("first_q_lane0", 32'(led[8]), 32'd0);
        for (int n = 0; n < 1000; n++) cycle(1'b0);
        chk("clean_1000", 32'(led[7:0]), 32'd0);

        // Two-cycle fault on lane 0 after cycle 10.
        do_reset();
        start = $urandom_range(20, 10);
        for (int n = 0; n < start; n++) cycle(1'b0);
        cycle(1'b1);
        cycle(1'b1);
        seen = 1'b0;
        for (int n = 0; n < 128 && !seen; n++) begin
            cycle(1'b0);
            if (led[0] === 1'b1) seen = 1'b1;
        end
        chk("fault_seen", 32'(seen), 32'd1);
        for (int n = 0; n < 100; n++) cycle(1'b0);
        chk("fault_sticky", 32'(led[0]), 32'd1);
        chk("other_lanes", 32'(led[7:1]), 32'd0);

        // Asynchronous reset in the middle of a cycle clears flags immediately.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_clear", 32'(led[7:0]), 32'd0);
        model_reset();
        @(negedge clk);
        check_reset_view("mid_reset");
        rst_n = 1'b1;
        for (int n = 0; n < 200; n++) cycle(1'b0);
        chk("post_reset_clean", 32'(led[7:0]), 32'd0);

        // Loopback toggling with no effect on flags.
        for (int n = 0; n < 4; n++) begin
            rx = n[0];
            #1;
            chk("tx_toggle", 32'(tx), 32'(n[0]));
            chk("tx_no_err", 32'(led[7:0]), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
